// File: rtl/mu0_core.sv
// mu0_core: MU0 16-bit accumulator CPU with a 12-bit word address space.
// Every instruction takes two cycles, a FETCH phase followed by an EXEC
// phase. STP halts the core until Reset is asserted.
//
// Ports:
//   Clk       in   1   clock; all state updates on the rising edge
//   Reset     in   1   synchronous, active-high reset
//   Data_in   in   16  memory read data, valid combinationally in the same cycle
//   Rd        out  1   memory read strobe
//   Wr        out  1   memory write strobe; memory stores Data_out at Address on rising Clk
//   Address   out  12  memory word address
//   Data_out  out  16  write data (always ACC)
//   Halted    out  1   high once STP has executed; held until Reset
module mu0_core (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Data_in,
    output logic        Rd,
    output logic        Wr,
    output logic [11:0] Address,
    output logic [15:0] Data_out,
    output logic        Halted
);

    localparam logic PH_FETCH = 1'b0;
    localparam logic PH_EXEC  = 1'b1;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    logic [11:0] pc;
    logic [15:0] acc;
    logic [15:0] ir;
    logic        phase;
    logic        halted;

    logic [3:0]  opcode;
    logic [11:0] operand;

    assign opcode  = ir[15:12];
    assign operand = ir[11:0];

    // A halted core sits in EXEC of its STP, so Address keeps showing the
    // STP operand without any extra holding register.
    always_comb begin
        Rd      = 1'b0;
        Wr      = 1'b0;
        Address = (phase == PH_FETCH) ? pc : operand;
        if (!halted) begin
            if (phase == PH_FETCH) begin
                Rd = 1'b1;
            end else begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: Rd = 1'b1;
                    // Reset gates the write strobe so a store interrupted by
                    // reset never reaches memory on that same edge.
                    OP_STA:                 Wr = !Reset;
                    default:                ;
                endcase
            end
        end
    end

    assign Data_out = acc;
    assign Halted   = halted;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc     <= '0;
            acc    <= '0;
            ir     <= '0;
            phase  <= PH_FETCH;
            halted <= 1'b0;
        end else if (!halted) begin
            if (phase == PH_FETCH) begin
                ir    <= Data_in;
                pc    <= pc + 12'd1;
                phase <= PH_EXEC;
            end else begin
                phase <= PH_FETCH;
                case (opcode)
                    OP_LDA: acc <= Data_in;
                    OP_ADD: acc <= acc + Data_in;
                    OP_SUB: acc <= acc - Data_in;
                    OP_JMP: pc  <= operand;
                    OP_JGE: if (!acc[15]) pc <= operand;
                    OP_JNE: if (acc != '0) pc <= operand;
                    OP_STP: begin
                        halted <= 1'b1;
                        phase  <= PH_EXEC;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mu0_core.sv
// tb_mu0_core: directed-vector bench for mu0_core with a behavioural
// 4096 x 16 memory (combinational read gated by Rd, synchronous write).
module tb_mu0_core;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Data_in;
    logic        Rd;
    logic        Wr;
    logic [11:0] Address;
    logic [15:0] Data_out;
    logic        Halted;

    logic [15:0] mem [0:4095];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    mu0_core dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Data_in  (Data_in),
        .Rd       (Rd),
        .Wr       (Wr),
        .Address  (Address),
        .Data_out (Data_out),
        .Halted   (Halted)
    );

    always #5 Clk = ~Clk;

    assign Data_in = Rd ? mem[Address] : 16'h0000;

    always @(posedge Clk) begin
        if (Wr) mem[Address] <= Data_out;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] s);
        return {op, s};
    endfunction

    task automatic clear_mem();
        for (int unsigned i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    // Reset held for one rising edge; returns 1 time unit after that edge.
    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    // Counts edges until Halted, bounded by max; also counts fetches of 0x007.
    task automatic run(input int unsigned max, output int unsigned cycles,
                       output int unsigned loop_fetches);
        cycles = 0;
        loop_fetches = 0;
        while (!Halted && cycles < max) begin
            if (Rd && Address == 12'h007) loop_fetches++;
            @(posedge Clk);
            #1;
            cycles++;
        end
        if (!Halted) check("halt_timeout", {31'd0, Halted}, 32'd1);
    endtask

    int unsigned cyc;
    int unsigned loops;

    initial begin
        // 1: reset state, arithmetic program
        clear_mem();
        mem[12'h000] = ins(4'h0, 12'h010);
        mem[12'h001] = ins(4'h2, 12'h011);
        mem[12'h002] = ins(4'h3, 12'h012);
        mem[12'h003] = ins(4'h1, 12'h013);
        mem[12'h004] = ins(4'h7, 12'h000);
        mem[12'h010] = 16'h0005;
        mem[12'h011] = 16'h0003;
        mem[12'h012] = 16'h0001;
        do_reset();
        check("rst_halted",  {31'd0, Halted}, 32'd0);
        check("rst_address", {20'd0, Address}, 32'h000);
        check("rst_rd",      {31'd0, Rd}, 32'd1);
        check("rst_wr",      {31'd0, Wr}, 32'd0);
        check("rst_acc",     {16'd0, Data_out}, 32'h0000);

        // 2: arithmetic
        run(100, cyc, loops);
        check("arith_cycles", cyc, 32'd10);
        check("arith_mem13",  {16'd0, mem[12'h013]}, 32'h0007);
        check("arith_acc",    {16'd0, Data_out}, 32'h0007);

        // 3: overflow/underflow and a NOP (opcode F) that must not touch ACC
        clear_mem();
        mem[12'h000] = ins(4'h0, 12'h020);
        mem[12'h001] = ins(4'h2, 12'h021);
        mem[12'h002] = ins(4'h1, 12'h030);
        mem[12'h003] = ins(4'h3, 12'h021);
        mem[12'h004] = ins(4'h1, 12'h031);
        mem[12'h005] = ins(4'hF, 12'h021);
        mem[12'h006] = ins(4'h7, 12'h000);
        mem[12'h020] = 16'hFFFF;
        mem[12'h021] = 16'h0001;
        mem[12'h030] = 16'h5555;
        mem[12'h031] = 16'h5555;
        do_reset();
        run(100, cyc, loops);
        check("ovf_cycles", cyc, 32'd14);
        check("ovf_wrap0",  {16'd0, mem[12'h030]}, 32'h0000);
        check("ovf_wrapF",  {16'd0, mem[12'h031]}, 32'hFFFF);
        check("ovf_acc",    {16'd0, Data_out}, 32'hFFFF);

        // PC wrap 0xFFF -> 0x000: JNE not taken (ACC=0), JMP to 0xFFF,
        // LDA there, wrap to 0, JNE now taken to STP.
        clear_mem();
        mem[12'h000] = ins(4'h6, 12'h005);
        mem[12'h001] = ins(4'h4, 12'hFFF);
        mem[12'hFFF] = ins(4'h0, 12'h060);
        mem[12'h005] = ins(4'h7, 12'h0CD);
        mem[12'h060] = 16'h0042;
        do_reset();
        run(100, cyc, loops);
        check("wrap_cycles",  cyc, 32'd10);
        check("wrap_acc",     {16'd0, Data_out}, 32'h0042);
        check("wrap_address", {20'd0, Address}, 32'h0CD);

        // 4: branches and countdown loop (wrong branch paths halt early)
        clear_mem();
        mem[12'h000] = ins(4'h0, 12'h040);
        mem[12'h001] = ins(4'h5, 12'h00A);
        mem[12'h002] = ins(4'h0, 12'h041);
        mem[12'h003] = ins(4'h6, 12'h00A);
        mem[12'h004] = ins(4'h5, 12'h006);
        mem[12'h005] = ins(4'h7, 12'h0AB);
        mem[12'h006] = ins(4'h0, 12'h042);
        mem[12'h007] = ins(4'h3, 12'h043);
        mem[12'h008] = ins(4'h6, 12'h007);
        mem[12'h009] = ins(4'h1, 12'h045);
        mem[12'h00A] = ins(4'h7, 12'h0AB);
        mem[12'h040] = 16'h8000;
        mem[12'h041] = 16'h0000;
        mem[12'h042] = 16'h0003;
        mem[12'h043] = 16'h0001;
        mem[12'h045] = 16'hDEAD;
        do_reset();
        run(200, cyc, loops);
        check("br_cycles", cyc, 32'd28);
        check("br_loops",  loops, 32'd3);
        check("br_mem45",  {16'd0, mem[12'h045]}, 32'h0000);
        check("br_acc",    {16'd0, Data_out}, 32'h0000);

        // 5: halt hold, then reset restarts the program
        for (int unsigned i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            check("hold_rd", {31'd0, Rd}, 32'd0);
            check("hold_wr", {31'd0, Wr}, 32'd0);
        end
        check("hold_halted",  {31'd0, Halted}, 32'd1);
        check("hold_acc",     {16'd0, Data_out}, 32'h0000);
        check("hold_mem45",   {16'd0, mem[12'h045]}, 32'h0000);
        check("hold_address", {20'd0, Address}, 32'h0AB);
        do_reset();
        check("rst2_address", {20'd0, Address}, 32'h000);
        check("rst2_rd",      {31'd0, Rd}, 32'd1);
        check("rst2_halted",  {31'd0, Halted}, 32'd0);
        run(200, cyc, loops);
        check("rerun_cycles", cyc, 32'd28);
        check("rerun_loops",  loops, 32'd3);

        // 6: reset during EXEC of STA suppresses the store
        clear_mem();
        mem[12'h000] = ins(4'h0, 12'h050);
        mem[12'h001] = ins(4'h1, 12'h051);
        mem[12'h002] = ins(4'h7, 12'h000);
        mem[12'h050] = 16'h1234;
        do_reset();
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        check("sta_wr",      {31'd0, Wr}, 32'd1);
        check("sta_address", {20'd0, Address}, 32'h051);
        Reset = 1'b1;
        #1;
        check("sta_rst_wr",  {31'd0, Wr}, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("sta_nowrite", {16'd0, mem[12'h051]}, 32'h0000);
        check("sta_fetch_a", {20'd0, Address}, 32'h000);
        check("sta_fetch_rd", {31'd0, Rd}, 32'd1);
        check("sta_fetch_wr", {31'd0, Wr}, 32'd0);
        run(100, cyc, loops);
        check("sta_cycles",  cyc, 32'd6);
        check("sta_written", {16'd0, mem[12'h051]}, 32'h1234);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
